delay_line_ctrl: RTL and testbench
==================================

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter DEPTH, default 8, RAM depth in samples; SHALL be a power of two, >= 2.
REQ-003 Localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 n_reset  input  1  asynchronous, active-low reset.
REQ-006 delay  input  ADDR_WIDTH  delay select; effective delay D = delay+1 samples (1..DEPTH).
REQ-007 in_data  input  WIDTH  input sample; in_valid input 1; in_ready output 1.
REQ-008 out_data  output  WIDTH  delayed sample; out_valid output 1; out_ready input 1.
REQ-009 ram_wr_addr  output  ADDR_WIDTH; ram_wr_en output 1; ram_wr_data output WIDTH -- external dual-port RAM write port.
REQ-010 ram_rd_addr  output  ADDR_WIDTH; ram_rd_en output 1 -- RAM read port request.
REQ-011 ram_rd_data  input  WIDTH  RAM read data, valid exactly one cycle after ram_rd_en; read-before-write on address collision.

Function
REQ-012 Block SHALL be a circular-buffer delay: k-th accepted output sample = (k-D)-th accepted input sample, or zero when k < D (counting since reset).
REQ-013 State machine SHALL have states IDLE, WAIT, OUT.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready ("accept") -> WAIT.
REQ-015 On accept, same cycle: ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=in_data, ram_rd_en=1, ram_rd_addr=(wr_ptr-delay-1) mod DEPTH.
REQ-016 ram_wr_en and ram_rd_en SHALL be 0 in every cycle without an accept.
REQ-017 On accept, wr_ptr SHALL increment modulo DEPTH (DEPTH-1 wraps to 0).
REQ-018 delay SHALL be sampled only at accept; changes take effect from the next accepted sample.
REQ-019 WAIT (exactly one cycle): in_ready=0; register out_data = ram_rd_data if fill count (before the accept) >= D, else 0; -> OUT.
REQ-020 Fill count SHALL increment on each accept and saturate at DEPTH; it is the sole source of zero-priming (RAM contents are never trusted after reset).
REQ-021 OUT: out_valid=1, out_data stable until out_ready=1.
REQ-022 OUT: in_ready = out_ready; out_valid&out_ready with no in_valid -> IDLE; with simultaneous accept -> WAIT (throughput 1 sample per 2 cycles).
REQ-023 D=DEPTH SHALL read the slot being written the same cycle and yield its previous value (read-before-write).
REQ-024 in_ready SHALL not depend combinationally on in_valid.
REQ-025 Input not accepted (in_valid=1, in_ready=0) SHALL be held by the source; block SHALL not drop or duplicate samples.

Reset
REQ-026 n_reset=0 SHALL asynchronously force: state IDLE, wr_ptr=0, fill count=0, out_valid=0, out_data=0, ram_wr_en=0, ram_rd_en=0.
REQ-027 in_ready SHALL be 0 while n_reset=0 and 1 from the first clock edge after release.
REQ-028 Reset during WAIT or OUT SHALL discard the in-flight sample; subsequent outputs SHALL be zero-primed per REQ-020 regardless of stale RAM contents.

Verification
REQ-029 delay=2 (D=3), inputs 1,2,3,4,5, out_ready=1 -> outputs 0,0,0,1,2.
REQ-030 delay=DEPTH-1 (D=8), inputs 1..10 -> outputs 0 x8 then 1,2; ram_rd_addr equals ram_wr_addr on every accept.
REQ-031 delay=0 (D=1), 20 inputs across wr_ptr wrap -> each output equals previous input; wr_ptr 7->0 observed on ram_wr_addr.
REQ-032 out_ready held 0 for 5 cycles in OUT -> out_data stable, in_ready=0, no RAM enables; release -> stream resumes without loss.
REQ-033 Stream 1..12 with D=3, assert n_reset low in WAIT, release, stream 20,21,22,23 -> outputs 0,0,0,20.
REQ-034 Change delay 2->0 mid-stream (inputs 1..6, change before 5th accept) -> outputs 0,0,0,1,4,5.

Source files
------------

// File: rtl/delay_line_ctrl_if.sv
// rtl/delay_line_ctrl_if.sv - sample stream and external dual-port RAM bundle for delay_line_ctrl
interface delay_line_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] delay;

  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;

  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;

  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic                  ram_wr_en;
  logic [WIDTH-1:0]      ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic                  ram_rd_en;
  logic [WIDTH-1:0]      ram_rd_data;

  modport slave (
    input  delay, in_data, in_valid, out_ready, ram_rd_data,
    output in_ready, out_data, out_valid,
           ram_wr_addr, ram_wr_en, ram_wr_data, ram_rd_addr, ram_rd_en
  );

  modport master (
    output delay, in_data, in_valid, out_ready, ram_rd_data,
    input  in_ready, out_data, out_valid,
           ram_wr_addr, ram_wr_en, ram_wr_data, ram_rd_addr, ram_rd_en
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// rtl/delay_line_ctrl.sv - circular-buffer sample delay over an external dual-port RAM
module delay_line_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  delay_line_ctrl_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FILL_MAX = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  fill_q, fill_d;
  logic                  primed_q, primed_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  run_q;

  logic                  in_ready;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  delay_len;

  assign delay_len = {1'b0, bus.delay} + CNT_WIDTH'(1);

  // run_q keeps in_ready low during reset and until the first edge after release
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      primed_q   <= 1'b0;
      out_data_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      primed_q   <= primed_d;
      out_data_q <= out_data_d;
      run_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    primed_d   = primed_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = run_q;
      end
      S_WAIT: begin
        out_data_d = primed_q ? bus.ram_rd_data : '0;
        state_d    = S_OUT;
      end
      S_OUT: begin
        in_ready = run_q & bus.out_ready;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    accept = bus.in_valid & in_ready;

    // The fill count before this accept decides whether the RAM slot holds real history
    if (accept) begin
      state_d  = S_WAIT;
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + CNT_WIDTH'(1);
      primed_d = (fill_q >= delay_len);
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.out_data    = out_data_q;
  assign bus.ram_wr_en   = accept;
  assign bus.ram_wr_addr = wr_ptr_q;
  assign bus.ram_wr_data = bus.in_data;
  assign bus.ram_rd_en   = accept;
  assign bus.ram_rd_addr = wr_ptr_q - bus.delay - ADDR_WIDTH'(1);
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb/tb_delay_line_ctrl.sv - self-checking bench for delay_line_ctrl with a behavioural delay model
module tb_delay_line_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  delay_line_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  delay_line_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // External RAM with stale junk so that zero-priming must come from the fill count
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end

  // Model: history of accepted inputs since reset, expected outputs queued per accept
  logic [WIDTH-1:0] ins[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got[$];
  logic [WIDTH-1:0] exp_lit[$];
  logic [2:0]       model_wp;
  int               n_in, n_out;
  int               addr_neq;
  bit               saw_wrap;
  logic [2:0]       last_wr_addr;
  bit               hold_prev;
  logic [WIDTH-1:0] prev_data;

  always @(negedge clk) begin
    if (!n_reset) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_wr_en", bus.ram_wr_en, 0);
      chk("rst_rd_en", bus.ram_rd_en, 0);
      ins.delete(); exp_q.delete(); got.delete();
      model_wp = 0; n_in = 0; n_out = 0; hold_prev = 0;
    end else begin
      automatic bit acc = bus.in_valid && bus.in_ready;
      automatic bit hs  = bus.out_valid && bus.out_ready;
      automatic int d   = int'(bus.delay) + 1;
      automatic int k   = ins.size();
      automatic logic [2:0] exp_rd = model_wp - bus.delay - 3'd1;
      chk("wr_en", bus.ram_wr_en, acc);
      chk("rd_en", bus.ram_rd_en, acc);
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
      if (hold_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, prev_data);
      end
      if (acc) begin
        chk("one_in_flight", (n_in == n_out) || hs, 1);
        chk("wr_addr", bus.ram_wr_addr, model_wp);
        chk("wr_data", bus.ram_wr_data, bus.in_data);
        chk("rd_addr", bus.ram_rd_addr, exp_rd);
        if (bus.ram_rd_addr != bus.ram_wr_addr) addr_neq++;
        if (last_wr_addr == 3'd7 && bus.ram_wr_addr == 3'd0) saw_wrap = 1;
        last_wr_addr = bus.ram_wr_addr;
        exp_q.push_back((k >= d) ? ins[k-d] : '0);
        ins.push_back(bus.in_data);
        model_wp = model_wp + 3'd1;
        n_in++;
      end
      if (hs) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk($sformatf("out_data[%0d]", n_out), bus.out_data, exp_q.pop_front());
        got.push_back(bus.out_data);
        n_out++;
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", bus.in_ready, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 n_reset = 1'b0;
    bus.in_valid = 1'b0;
    release_reset();
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    bit done = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", done, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && n_out != n_in; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_complete", n_out == n_in, 1);
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, got.size(), exp_lit.size());
    for (int i = 0; i < got.size() && i < exp_lit.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], exp_lit[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.delay = '0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    saw_wrap = 0; last_wr_addr = 3'd0; addr_neq = 0;
    release_reset();

    // D=3: 1..5 -> 0,0,0,1,2
    bus.delay = 3'd2;
    for (int i = 1; i <= 5; i++) send(8'(i));
    drain();
    exp_lit = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    check_got("d3");

    // D=8: read and write slots coincide, read-before-write gives previous value
    do_reset();
    bus.delay = 3'd7; addr_neq = 0;
    for (int i = 1; i <= 10; i++) send(8'(i));
    drain();
    exp_lit = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    check_got("d8");
    chk("d8_rd_eq_wr", addr_neq, 0);

    // D=1 across wr_ptr wrap
    do_reset();
    bus.delay = 3'd0; saw_wrap = 0;
    for (int i = 0; i < 20; i++) send(8'(50 + i));
    drain();
    exp_lit.delete();
    exp_lit.push_back(8'd0);
    for (int i = 0; i < 19; i++) exp_lit.push_back(8'(50 + i));
    check_got("d1");
    chk("d1_wrap_seen", saw_wrap, 1);

    // Backpressure: hold out_ready low for 5 cycles in OUT
    do_reset();
    bus.delay = 3'd1;
    send(8'd1); send(8'd2); send(8'd3);
    bus.out_ready = 1'b0;
    bus.in_data = 8'd4; bus.in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_data", bus.out_data, 1);
    chk("stall_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    send(8'd4); send(8'd5);
    drain();
    exp_lit = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    check_got("stall");

    // Reset while a sample is in WAIT; stale RAM must not leak out afterwards
    do_reset();
    bus.delay = 3'd2;
    for (int i = 1; i <= 12; i++) send(8'(i));
    chk("pre_rst_ready", bus.in_ready, 0);
    chk("pre_rst_valid", bus.out_valid, 0);
    exp_lit = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    check_got("pre_rst");
    n_reset = 1'b0;
    bus.in_valid = 1'b0;
    release_reset();
    for (int i = 20; i <= 23; i++) send(8'(i));
    drain();
    exp_lit = '{8'd0, 8'd0, 8'd0, 8'd20};
    check_got("post_rst");

    // Delay 2 -> 0 before the 5th accept
    do_reset();
    bus.delay = 3'd2;
    for (int i = 1; i <= 4; i++) send(8'(i));
    bus.delay = 3'd0;
    send(8'd5); send(8'd6);
    drain();
    exp_lit = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd4, 8'd5};
    check_got("dchg");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
